io_bus_controller: RTL and testbench

//   Sequences every CPU load/store that targets the memory-mapped I/O window
//   (0xF00000xx). It decodes the address, performs a one-wait-state access to
//   the HEX, LEDR and LEDG output registers and to the KEY and SW inputs, and

---
 rtl/io_bus_controller_if.sv | 22 ++
 rtl/io_bus_controller.sv | 174 +++++++++++++++++
 tb/tb_io_bus_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_controller_if.sv
// rtl/io_bus_controller_if.sv - CPU load/store handshake bundle for the memory-mapped I/O window.
interface io_bus_controller_if #(
    parameter int DBITS = 32
);
    logic             req;
    logic             we;
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             is_io;
    logic             ready;
    logic [DBITS-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  is_io, ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output is_io, ready, rdata
    );
endinterface

// File: rtl/io_bus_controller.sv
// rtl/io_bus_controller.sv - one-wait-state I/O window controller: HEX/LEDR/LEDG registers, synchronised SW, debounced KEY.
// Optional feature macro: KEY_EDGE_LATCH_EN (sticky KEY press flags returned in KEY[7:4], cleared on KEY load).
module io_bus_controller #(
    parameter int                     DBITS           = 32,
    parameter logic [DBITS-1:0]       ADDR_HEX        = 32'hF0000000,
    parameter logic [DBITS-1:0]       ADDR_LEDR       = 32'hF0000004,
    parameter logic [DBITS-1:0]       ADDR_LEDG       = 32'hF0000008,
    parameter logic [DBITS-1:0]       ADDR_KEY        = 32'hF0000010,
    parameter logic [DBITS-1:0]       ADDR_SW         = 32'hF0000014,
    parameter int                     DB_CNT_BITS     = 16,
    parameter logic [DB_CNT_BITS-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    io_bus_controller_if.slave   bus,
    input  logic [3:0]           key_in,
    input  logic [9:0]           sw_in,
    output logic [15:0]          hex_out,
    output logic [9:0]           ledr_out,
    output logic [7:0]           ledg_out
);
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [DB_CNT_BITS-1:0] DB_LAST = DEBOUNCE_CYCLES - 1'b1;

    state_t                        state_q, state_d;
    logic [DBITS-1:0]              rdata_q, rdata_d;
    logic [15:0]                   hex_q, hex_d;
    logic [9:0]                    ledr_q, ledr_d;
    logic [7:0]                    ledg_q, ledg_d;
    logic [3:0]                    key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [9:0]                    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [3:0]                    key_db_q, key_db_d;
    logic [3:0][DB_CNT_BITS-1:0]   db_cnt_q, db_cnt_d;

    logic             accept;
    logic             sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;
    logic [3:0]       key_sync;
    logic [DBITS-1:0] key_rd;
    logic [DBITS-1:0] rd_mux;

    assign bus.is_io = (bus.addr[DBITS-1:8] == ADDR_HEX[DBITS-1:8]);
    assign accept    = (state_q == IDLE) && bus.req && bus.is_io;

    // Word decode: byte lane bits are don't-care.
    assign sel_hex  = (bus.addr[DBITS-1:2] == ADDR_HEX[DBITS-1:2]);
    assign sel_ledr = (bus.addr[DBITS-1:2] == ADDR_LEDR[DBITS-1:2]);
    assign sel_ledg = (bus.addr[DBITS-1:2] == ADDR_LEDG[DBITS-1:2]);
    assign sel_key  = (bus.addr[DBITS-1:2] == ADDR_KEY[DBITS-1:2]);
    assign sel_sw   = (bus.addr[DBITS-1:2] == ADDR_SW[DBITS-1:2]);

    assign key_sync = ~key_s2_q;

    always_comb begin
        key_s1_d = key_in;
        key_s2_d = key_s1_q;
        sw_s1_d  = sw_in;
        sw_s2_d  = sw_s1_q;
    end

    // Counter only runs while sync disagrees with the accepted state; >= keeps it from wrapping.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (key_sync[i] == key_db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] >= DB_LAST) begin
                key_db_d[i] = key_sync[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef KEY_EDGE_LATCH_EN
    logic [3:0] key_flag_q, key_flag_d;

    // Clear first, then OR in new edges so a press landing on the read edge is kept.
    always_comb begin
        key_flag_d = key_flag_q;
        if (accept && !bus.we && sel_key) begin
            key_flag_d = '0;
        end
        key_flag_d = key_flag_d | (key_db_d & ~key_db_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_flag_q <= '0;
        end else begin
            key_flag_q <= key_flag_d;
        end
    end

    assign key_rd = {{(DBITS-8){1'b0}}, key_flag_q, key_db_q};
`else
    assign key_rd = {{(DBITS-4){1'b0}}, key_db_q};
`endif

    always_comb begin
        rd_mux = '0;
        if (sel_hex) begin
            rd_mux = {{(DBITS-16){1'b0}}, hex_q};
        end else if (sel_ledr) begin
            rd_mux = {{(DBITS-10){1'b0}}, ledr_q};
        end else if (sel_ledg) begin
            rd_mux = {{(DBITS-8){1'b0}}, ledg_q};
        end else if (sel_key) begin
            rd_mux = key_rd;
        end else if (sel_sw) begin
            rd_mux = {{(DBITS-10){1'b0}}, sw_s2_q};
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        case (state_q)
            IDLE: begin
                if (bus.req && bus.is_io) begin
                    state_d = RESP;
                    if (bus.we) begin
                        if (sel_hex)  hex_d  = bus.wdata[15:0];
                        if (sel_ledr) ledr_d = bus.wdata[9:0];
                        if (sel_ledg) ledg_d = bus.wdata[7:0];
                    end else begin
                        rdata_d = rd_mux;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            hex_q    <= '0;
            ledr_q   <= '0;
            ledg_q   <= '0;
            key_s1_q <= 4'hF;
            key_s2_q <= 4'hF;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_db_q <= '0;
            db_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            key_db_q <= key_db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign bus.ready = (state_q == RESP);
    assign bus.rdata = rdata_q;
    assign hex_out   = hex_q;
    assign ledr_out  = ledr_q;
    assign ledg_out  = ledg_q;
endmodule

// File: tb/tb_io_bus_controller.sv
// tb/tb_io_bus_controller.sv - scoreboard bench for io_bus_controller with a register-level reference model.
module tb_io_bus_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_in;
    logic [9:0] sw_in;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    always #5 clk = ~clk;

    io_bus_controller_if #(.DBITS(32)) bus ();

    io_bus_controller #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .key_in   (key_in),
        .sw_in    (sw_in),
        .hex_out  (hex_out),
        .ledr_out (ledr_out),
        .ledg_out (ledg_out)
    );

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_ready = 1'b0;

    // Reference model state (KEY state kept as pressed=1)
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_key;
    logic [3:0]  m_flags;
    logic [9:0]  m_sw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            chk("ready_single_cycle", 32'(prev_ready), 32'd0);
            chk("ready_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_load) chk("rdata", bus.rdata, e.data);
            end
        end
        prev_ready = (bus.ready === 1'b1);
    end

    function automatic logic [31:0] model_load(input logic [31:0] a);
        case ({a[7:2], 2'b00})
            8'h00: return {16'b0, m_hex};
            8'h04: return {22'b0, m_ledr};
            8'h08: return {24'b0, m_ledg};
`ifdef KEY_EDGE_LATCH_EN
            8'h10: return {24'b0, m_flags, m_key};
`else
            8'h10: return {28'b0, m_key};
`endif
            8'h14: return {22'b0, m_sw};
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] exp);
        exp = 32'b0;
        if (we) begin
            case ({a[7:2], 2'b00})
                8'h00: m_hex  = wd[15:0];
                8'h04: m_ledr = wd[9:0];
                8'h08: m_ledg = wd[7:0];
                default: ;
            endcase
        end else begin
            exp = model_load(a);
            if ({a[7:2], 2'b00} == 8'h10) m_flags = 4'b0;
        end
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit io);
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.addr = a; bus.wdata = wd;
        if (io) sb_q.push_back('{is_load: !we, data: exp_rd});
        #1 chk("is_io", 32'(bus.is_io), 32'(io));
        @(posedge clk); #1;
        if (io) begin
            chk("ready_latency", 32'(bus.ready), 32'd1);
        end else begin
            repeat (4) begin
                chk("no_ready_non_io", 32'(bus.ready), 32'd0);
                @(posedge clk); #1;
            end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic mop(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e;
        model_op(we, a, wd, e);
        access(we, a, wd, e, 1'b1);
    endtask

    task automatic set_inputs(input logic [3:0] k, input logic [9:0] s);
        logic [3:0] pressed;
        @(negedge clk);
        key_in = k; sw_in = s;
        repeat (12) @(negedge clk);
        pressed = ~k;
        m_flags = m_flags | (pressed & ~m_key);
        m_key = pressed;
        m_sw = s;
    endtask

    task automatic chk_outputs();
        chk("hex_out", 32'(hex_out), 32'(m_hex));
        chk("ledr_out", 32'(ledr_out), 32'(m_ledr));
        chk("ledg_out", 32'(ledg_out), 32'(m_ledg));
    endtask

    initial begin
        logic [31:0] offs [8];
        logic [31:0] a, wd;
        logic        we;

        offs = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h1C, 32'h20, 32'hFC};
        m_hex = '0; m_ledr = '0; m_ledg = '0; m_key = '0; m_flags = '0; m_sw = '0;
        key_in = 4'hF; sw_in = '0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        chk_outputs();
        @(negedge clk) reset_n = 1'b1;

        // Reset in the middle of RESP
        mop(1'b1, 32'hF0000004, 32'h0000_0155);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'hF0000000; bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        chk("pre_reset_ready", 32'(bus.ready), 32'd1);
        chk("pre_reset_hex", 32'(hex_out), 32'h1234);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_resp_ready", 32'(bus.ready), 32'd0);
        m_hex = '0; m_ledr = '0; m_ledg = '0;
        chk_outputs();
        bus.req = 1'b0;
        @(negedge clk) reset_n = 1'b1;

        // HEX store/load
        mop(1'b1, 32'hF0000000, 32'h0000BEEF);
        chk("hex_beef", 32'(hex_out), 32'h0000BEEF);
        mop(1'b0, 32'hF0000000, 32'h0);

        // LEDR all ones, dropped KEY store, unmapped load
        mop(1'b1, 32'hF0000004, 32'hFFFFFFFF);
        chk("ledr_3ff", 32'(ledr_out), 32'h3FF);
        mop(1'b1, 32'hF0000010, 32'hFFFFFFFF);
        mop(1'b0, 32'hF0000010, 32'h0);
        mop(1'b0, 32'hF000001C, 32'h0);

        // Back-to-back: req held through RESP is not accepted until the following edge
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'hF0000008; bus.wdata = 32'h0000_005A;
        sb_q.push_back('{is_load: 1'b0, data: 32'h0});
        sb_q.push_back('{is_load: 1'b0, data: 32'h0});
        @(posedge clk); #1;
        chk("b2b_first_ready", 32'(bus.ready), 32'd1);
        bus.wdata = 32'h0000_00C3;
        @(posedge clk); #1;
        chk("b2b_gap", 32'(bus.ready), 32'd0);
        chk("b2b_ledg_first", 32'(ledg_out), 32'h5A);
        @(posedge clk); #1;
        chk("b2b_second_ready", 32'(bus.ready), 32'd1);
        chk("b2b_ledg_second", 32'(ledg_out), 32'hC3);
        bus.req = 1'b0;
        m_ledg = 8'hC3;
        @(posedge clk); #1;

        // KEY glitch then long press
        @(negedge clk) key_in[2] = 1'b0;
        repeat (2) @(negedge clk);
        key_in[2] = 1'b1;
        repeat (10) @(negedge clk);
        mop(1'b0, 32'hF0000010, 32'h0);
        set_inputs(4'hB, m_sw);
        mop(1'b0, 32'hF0000011, 32'h0);
        set_inputs(4'hF, m_sw);

        // SW path and non-I/O access
        set_inputs(4'hF, 10'h2A5);
        mop(1'b0, 32'hF0000014, 32'h0);
        access(1'b1, 32'h00001000, 32'h12345678, 32'h0, 1'b0);
        chk_outputs();

`ifdef KEY_EDGE_LATCH_EN
        mop(1'b0, 32'hF0000010, 32'h0);
        set_inputs(4'hE, m_sw);
        set_inputs(4'hF, m_sw);
        chk("flags_model_sanity", {24'b0, m_flags, m_key}, 32'h10);
        mop(1'b0, 32'hF0000010, 32'h0);
        mop(1'b0, 32'hF0000010, 32'h0);
        // Debounced edge of KEY1 lands exactly on the KEY load accept edge
        @(negedge clk) key_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        access(1'b0, 32'hF0000010, 32'h0, 32'h0, 1'b1);
        m_key = 4'b0010; m_flags = 4'b0010;
        mop(1'b0, 32'hF0000010, 32'h0);
        set_inputs(4'hF, m_sw);
`endif

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) set_inputs(4'($urandom), 10'($urandom));
            we = 1'($urandom);
            wd = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                a = {4'h0, 28'($urandom)};
                access(we, a, wd, 32'h0, 1'b0);
            end else begin
                a = 32'hF0000000 | offs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
                mop(we, a, wd);
            end
            chk_outputs();
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
